hilo_muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer and HI/LO register owner for the five-stage MIPS pipeline, sitting beside the EX stage. It accepts MULT/MULTU/DIV/DIVU from EX and runs a 32-iteration shift-add or restoring-divide loop. It drives the HI/LO architectural registers and services MFHI/MFLO/MTHI/MTLO. It raises a pipeline stall whenever the front end touches HI/LO or issues a new operation while a computation is in flight.

---
 rtl/hilo_pkg.sv | 23 ++
 rtl/muldiv_iter.sv | 38 +++
 rtl/hilo_muldiv_ctrl.sv | 135 +++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude of a 32-bit operand; only signed ops fold negative values.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide
// on the {acc,aux} pair. Purely combinational.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN:0]   acc,
    input  logic [XLEN-1:0] aux,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN:0]   acc_nxt,
    output logic [XLEN-1:0] aux_nxt
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shl;
    logic [XLEN+1:0] trial;

    // Multiply keeps the add carry in acc[XLEN]; divide uses the extra bit as headroom
    // for the shifted remainder before the trial subtract.
    always_comb begin
        sum   = acc + (aux[0] ? {1'b0, operand} : '0);
        shl   = {acc[XLEN-1:0], aux[XLEN-1]};
        trial = {1'b0, shl} - {2'b00, operand};
        if (is_div) begin
            if (!trial[XLEN+1]) begin
                acc_nxt = trial[XLEN:0];
                aux_nxt = {aux[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = shl;
                aux_nxt = {aux[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {1'b0, sum[XLEN:1]};
            aux_nxt = {sum[0], aux[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO and stalls the front end.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            rd_hi,
    input  logic            rd_lo,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            stall,
    output logic            div_zero
);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               neg_q;     // quotient / product sign
    logic               neg_r;     // remainder takes the dividend sign
    logic               b_zero;
    logic [XLEN:0]      acc;
    logic [XLEN-1:0]    aux;
    logic [XLEN-1:0]    operand;
    logic [XLEN-1:0]    orig_a;    // divide-by-zero returns the dividend untouched

    logic               sgn_op;
    logic [XLEN-1:0]    mag_a;
    logic [XLEN-1:0]    mag_b;
    logic [XLEN:0]      acc_nxt;
    logic [XLEN-1:0]    aux_nxt;
    logic [2*XLEN-1:0]  prod;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quo_fix;
    logic [XLEN-1:0]    rem_fix;

    assign sgn_op = ~op[0];
    assign mag_a  = mag32(src_a, sgn_op);
    assign mag_b  = mag32(src_b, sgn_op);

    assign stall = busy & (start | rd_hi | rd_lo | wr_hi | wr_lo);

    assign prod     = {acc[XLEN-1:0], aux};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -aux : aux;
    assign rem_fix  = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .is_div  (is_div),
        .acc     (acc),
        .aux     (aux),
        .operand (operand),
        .acc_nxt (acc_nxt),
        .aux_nxt (aux_nxt)
    );

    // Sequencer: latch at start, iterate ITER cycles, sign-fix into HI/LO, back to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            acc      <= '0;
            aux      <= '0;
            operand  <= '0;
            orig_a   <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // A start in the same cycle as MTHI/MTLO drops the write.
                        state   <= RUN;
                        busy    <= 1'b1;
                        count   <= '0;
                        is_div  <= op[1];
                        neg_q   <= sgn_op & (src_a[XLEN-1] ^ src_b[XLEN-1]);
                        neg_r   <= sgn_op & src_a[XLEN-1];
                        b_zero  <= (src_b == '0);
                        orig_a  <= src_a;
                        acc     <= '0;
                        aux     <= op[1] ? mag_a : mag_b;
                        operand <= op[1] ? mag_b : mag_a;
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    aux   <= aux_nxt;
                    count <= count + 1'b1;
                    if (count == CNT_W'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (is_div) begin
                        if (b_zero) begin
                            hi       <= orig_a;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed vectors, corner sequences,
// and random ops against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        rd_hi, rd_lo, wr_hi, wr_lo;
    logic [31:0] hi, lo;
    logic        busy, stall, div_zero;

    int total = 0;
    int bad   = 0;

    hilo_muldiv_ctrl #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .rd_hi    (rd_hi),
        .rd_lo    (rd_lo),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wdata    (wdata),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit / truncating integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint     p;
        logic [63:0] u;
        dz = 1'b0;
        h  = '0;
        l  = '0;
        if (o == 2'd0) begin
            p = longint'($signed(a)) * longint'($signed(b));
            {h, l} = p;
        end else if (o == 2'd1) begin
            u = {32'd0, a} * {32'd0, b};
            {h, l} = u;
        end else if (b == 32'd0) begin
            l  = 32'hFFFF_FFFF;
            h  = a;
            dz = 1'b1;
        end else if (o == 2'd2) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                l = a;
                h = 32'd0;
            end else begin
                l = $signed(a) / $signed(b);
                h = $signed(a) % $signed(b);
            end
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after FIX.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz);
        logic [31:0] oh, ol;
        int n;
        oh = hi;
        ol = lo;
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        chk("start_nostall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 16) chk("hold", {hi, lo}, {oh, ol});
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'd33);
        chk("hi", 64'(hi), 64'(eh));
        chk("lo", 64'(lo), 64'(el));
        chk("div_zero", 64'(div_zero), 64'(edz));
    endtask

    initial begin
        logic [31:0] mh, ml;
        logic        mdz;
        logic [31:0] oh;
        int          stall_cnt;
        int          n;

        vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'd0, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        vecs[5] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
        vecs[6] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[7] = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[8] = '{2'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
        rd_hi = 1'b0; rd_lo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_flags", {61'd0, busy, stall, div_zero}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
            @(negedge clk);
            chk("dz_clear", 64'(div_zero), 64'd0);
        end

        // MFLO during busy, plus a second start that must be stalled and dropped
        stall_cnt = 0;
        start = 1'b1; op = 2'd3; src_a = 32'd1000; src_b = 32'd7;
        for (int c = 0; c <= 34; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (c == 2) begin start = 1'b1; op = 2'd1; src_a = 32'd5; src_b = 32'd5; end
            if (c == 3) begin
                chk("start_stalled", 64'(stall), 64'd1);
                start = 1'b0;
                rd_lo = 1'b1;
            end
            if (c >= 4 && c <= 32) stall_cnt += int'(stall);
            if (c == 33) begin
                chk("mflo_release", {62'd0, stall, busy}, 64'd0);
                chk("mflo_value", {hi, lo}, {32'd6, 32'd142});
                rd_lo = 1'b0;
            end
            if (c == 34) chk("second_start_dropped", 64'(busy), 64'd0);
        end
        chk("mflo_stall_cycles", 64'(stall_cnt), 64'd29);

        // MTHI during busy is stalled and never lands
        oh = hi;
        start = 1'b1; op = 2'd0; src_a = 32'hFFFF_FFF9; src_b = 32'd3;
        for (int c = 0; c <= 33; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (c == 5) begin wr_hi = 1'b1; wdata = 32'hDEAD_BEEF; end
            if (c == 6) begin chk("mthi_stall", 64'(stall), 64'd1); wr_hi = 1'b0; end
            if (c == 10) chk("mthi_busy_hold", 64'(hi), 64'(oh));
            if (c == 33) chk("mthi_after_fix", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        end

        // Idle MTHI/MTLO
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mthi_mtlo_both", {hi, lo}, {32'h1234, 32'h1234});
        wr_lo = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mtlo_only", {hi, lo}, {32'h1234, 32'h5678});

        // start wins over a same-cycle write
        start = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'd3; wr_hi = 1'b1; wdata = 32'hAAAA;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        chk("start_wins", {31'd0, busy, hi}, {31'd0, 1'b1, 32'h1234});
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); end
        chk("start_wins_result", {hi, lo}, {32'd0, 32'd6});

        // Reset in the middle of a divide
        start = 1'b1; op = 2'd3; src_a = 32'hFFFF_FFFF; src_b = 32'd3;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("rst_mid", {31'd0, busy, hi, lo}, 96'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        // Random back-to-back ops against the model
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            model(ro, ra, rb, mh, ml, mdz);
            do_op(ro, ra, rb, mh, ml, mdz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
